i2s_phy_out: RTL and testbench

- I2S/TDM master transmitter to a DAC. Serialises byte slices from an AXI-Stream slave onto datao and generates lrck, all on bclk.
- It is the transmit counterpart of the ADC-side I2S input PHY and uses the same configuration semantics: tdm_num, word_width, valid_word_width, lrck polarity and lrck alignment.
- It sits between the audio mixer/DMA stream and the DAC pins.

---
 rtl/i2s_phy_out_if.sv | 12 +
 rtl/i2s_phy_out.sv | 197 +++++++++++++++++++
 tb/tb_i2s_phy_out.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_phy_out_if.sv
// Byte-slice AXI-Stream link feeding the I2S/TDM transmitter.
// Handshake: a beat transfers on the bclk edge where tvalid && tready; the
// master holds tdata/tlast stable while tvalid is high and tready is low.
interface i2s_phy_out_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/i2s_phy_out.sv
// I2S/TDM master transmitter: serialises AXI-Stream byte slices onto datao
// with a generated lrck, all on bclk. Config is shadowed at every frame start.
module i2s_phy_out #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 bclk,
  input  logic                 rst_n,
  i2s_phy_out_if.slave         s_axis,
  output logic                 lrck,
  output logic                 datao,
  input  logic [4:0]           i_tdm_num,
  input  logic [5:0]           i_word_width,
  input  logic [5:0]           i_valid_word_width,
  input  logic                 i_lrck_polarity,
  input  logic                 i_lrck_alignment,
  input  logic                 i_enable,
  output logic [31:0]          o_frame_num,
  output logic [CNT_WIDTH-1:0] o_underflow_count,
  output logic [CNT_WIDTH-1:0] o_tlast_err_count,
  output logic                 o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [5:0]           b_q, b_d;
  logic [4:0]           w_q, w_d;
  logic [4:0]           tdm_q, tdm_d;
  logic [5:0]           ww_q, ww_d;
  logic [5:0]           vww_q, vww_d;
  logic                 pol_q, pol_d;
  logic                 align_q, align_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 hold_last_q, hold_last_d;
  logic [7:0]           shift_q, shift_d;
  logic                 prev_bit_q, prev_bit_d;
  logic                 lrck_q, lrck_d;
  logic                 datao_q, datao_d;
  logic [31:0]          frame_q, frame_d;
  logic [CNT_WIDTH-1:0] unf_q, unf_d;
  logic [CNT_WIDTH-1:0] terr_q, terr_d;

  logic                 at_boundary;
  logic                 start;
  logic                 emit;
  logic                 bit_s;
  logic                 tlast_exp;
  logic [4:0]           tdm_c;
  logic [5:0]           ww_c;
  logic [5:0]           vww_c;
  logic                 pol_c;
  logic                 align_c;

  assign s_axis.tready     = rst_n & ~hold_valid_q;
  assign lrck              = lrck_q;
  assign datao             = datao_q;
  assign o_frame_num       = frame_q;
  assign o_underflow_count = unf_q;
  assign o_tlast_err_count = terr_q;
  assign o_dbg_state       = state_q;

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    w_d          = w_q;
    tdm_d        = tdm_q;
    ww_d         = ww_q;
    vww_d        = vww_q;
    pol_d        = pol_q;
    align_d      = align_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    shift_d      = shift_q;
    lrck_d       = lrck_q;
    frame_d      = frame_q;
    unf_d        = unf_q;
    terr_d       = terr_q;
    bit_s        = 1'b0;
    tlast_exp    = 1'b0;

    // b_q/w_q name the slot emitted at the coming edge; (0,0) is a frame boundary,
    // where i_enable decides between a new frame and IDLE.
    at_boundary = (b_q == 6'd0) && (w_q == 5'd0);
    start       = at_boundary && i_enable;
    emit        = start || ((state_q == RUN) && !at_boundary);

    tdm_c   = start ? i_tdm_num          : tdm_q;
    ww_c    = start ? i_word_width       : ww_q;
    vww_c   = start ? i_valid_word_width : vww_q;
    pol_c   = start ? i_lrck_polarity    : pol_q;
    align_c = start ? i_lrck_alignment   : align_q;

    if (start) begin
      tdm_d   = i_tdm_num;
      ww_d    = i_word_width;
      vww_d   = i_valid_word_width;
      pol_d   = i_lrck_polarity;
      align_d = i_lrck_alignment;
    end

    if ((state_q == RUN) && at_boundary) begin
      frame_d = frame_q + 32'd1;
    end

    if (emit) begin
      state_d = RUN;
      lrck_d  = (w_q < (tdm_c >> 1)) ? ~pol_c : pol_c;
      if (b_q < vww_c) begin
        if (b_q[2:0] == 3'd0) begin
          if (hold_valid_q) begin
            bit_s        = hold_q[7];
            shift_d      = {hold_q[6:0], 1'b0};
            hold_valid_d = 1'b0;
            tlast_exp    = (w_q == tdm_c - 5'd1) && (b_q == vww_c - 6'd8);
            if ((hold_last_q != tlast_exp) && (terr_q != {CNT_WIDTH{1'b1}})) begin
              terr_d = terr_q + 1'b1;
            end
          end else begin
            bit_s   = 1'b0;
            shift_d = 8'h00;
            if (unf_q != {CNT_WIDTH{1'b1}}) begin
              unf_d = unf_q + 1'b1;
            end
          end
        end else begin
          bit_s   = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
      if (b_q == ww_c - 6'd1) begin
        b_d = 6'd0;
        w_d = (w_q == tdm_c - 5'd1) ? 5'd0 : w_q + 5'd1;
      end else begin
        b_d = b_q + 6'd1;
      end
    end else begin
      state_d = IDLE;
      lrck_d  = i_lrck_polarity;
    end

    // Delayed alignment flushes the last LSB into the first cycle after the frame.
    datao_d    = align_c ? prev_bit_q : bit_s;
    prev_bit_d = bit_s;

    // A load empties hold before tready can rise, so this never collides with a load of valid data.
    if (s_axis.tvalid && s_axis.tready) begin
      hold_d       = s_axis.tdata;
      hold_last_d  = s_axis.tlast;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge bclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      b_q          <= 6'd0;
      w_q          <= 5'd0;
      tdm_q        <= 5'd2;
      ww_q         <= 6'd32;
      vww_q        <= 6'd24;
      pol_q        <= 1'b0;
      align_q      <= 1'b0;
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      shift_q      <= 8'h00;
      prev_bit_q   <= 1'b0;
      lrck_q       <= i_lrck_polarity;
      datao_q      <= 1'b0;
      frame_q      <= 32'd0;
      unf_q        <= '0;
      terr_q       <= '0;
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      w_q          <= w_d;
      tdm_q        <= tdm_d;
      ww_q         <= ww_d;
      vww_q        <= vww_d;
      pol_q        <= pol_d;
      align_q      <= align_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      shift_q      <= shift_d;
      prev_bit_q   <= prev_bit_d;
      lrck_q       <= lrck_d;
      datao_q      <= datao_d;
      frame_q      <= frame_d;
      unf_q        <= unf_d;
      terr_q       <= terr_d;
    end
  end

endmodule

// File: tb/tb_i2s_phy_out.sv
// Self-checking bench for i2s_phy_out: a per-cycle {lrck,datao} scoreboard
// built from a reference frame model, plus counter and reset checks.
module tb_i2s_phy_out;

  logic        bclk;
  logic        rst_n;
  logic        lrck;
  logic        datao;
  logic [4:0]  i_tdm_num;
  logic [5:0]  i_word_width;
  logic [5:0]  i_valid_word_width;
  logic        i_lrck_polarity;
  logic        i_lrck_alignment;
  logic        i_enable;
  logic [31:0] o_frame_num;
  logic [15:0] o_underflow_count;
  logic [15:0] o_tlast_err_count;
  logic        o_dbg_state;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  logic [8:0] src_q[$];
  logic [8:0] pend_q[$];
  logic [7:0] slot_q[$];

  i2s_phy_out_if s_axis();

  i2s_phy_out #(.CNT_WIDTH(16)) dut (
    .bclk               (bclk),
    .rst_n              (rst_n),
    .s_axis             (s_axis),
    .lrck               (lrck),
    .datao              (datao),
    .i_tdm_num          (i_tdm_num),
    .i_word_width       (i_word_width),
    .i_valid_word_width (i_valid_word_width),
    .i_lrck_polarity    (i_lrck_polarity),
    .i_lrck_alignment   (i_lrck_alignment),
    .i_enable           (i_enable),
    .o_frame_num        (o_frame_num),
    .o_underflow_count  (o_underflow_count),
    .o_tlast_err_count  (o_tlast_err_count),
    .o_dbg_state        (o_dbg_state)
  );

  // clock / watchdog
  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // stream driver: presents src_q head; a beat seen with tready here is taken at the next edge
  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    forever begin
      @(negedge bclk);
      #1;
      if (src_q.size() > 0) begin
        {s_axis.tlast, s_axis.tdata} = src_q[0];
        s_axis.tvalid = 1'b1;
        if (s_axis.tready) void'(src_q.pop_front());
      end else begin
        s_axis.tvalid = 1'b0;
      end
    end
  end

  task automatic set_cfg(input int tdm, input int ww, input int vww, input logic pol, input logic align);
    i_tdm_num          = 5'(tdm);
    i_word_width       = 6'(ww);
    i_valid_word_width = 6'(vww);
    i_lrck_polarity    = pol;
    i_lrck_alignment   = align;
  endtask

  task automatic do_reset();
    @(negedge bclk);
    rst_n    = 1'b0;
    i_enable = 1'b0;
    src_q.delete();
    pend_q.delete();
    slot_q.delete();
    exp_q.delete();
    repeat (2) @(negedge bclk);
    rst_n = 1'b1;
  endtask

  // Reference model: one {lrck,datao} entry per frame cycle, then n_idle idle cycles.
  task automatic build_exp(input int nfr, input int tdm, input int ww, input int vww,
                           input logic pol, input logic align, input int n_idle);
    int k = 0;
    logic prev = 1'b0;
    logic bt;
    logic l;
    logic [7:0] cur = 8'h00;
    for (int f = 0; f < nfr; f++)
      for (int w = 0; w < tdm; w++)
        for (int b = 0; b < ww; b++) begin
          l = (w < tdm / 2) ? ~pol : pol;
          if (b < vww) begin
            if (b % 8 == 0) begin
              cur = slot_q[k];
              k++;
            end
            bt = cur[7 - (b % 8)];
          end else begin
            bt = 1'b0;
          end
          exp_q.push_back({l, align ? prev : bt});
          prev = bt;
        end
    for (int i = 0; i < n_idle; i++) begin
      exp_q.push_back({pol, align ? prev : 1'b0});
      prev = 1'b0;
    end
  endtask

  task automatic prefill_check(input string name);
    repeat (3) @(negedge bclk);
    #2;
    checks++;
    if (s_axis.tready !== 1'b0) begin
      errors++;
      $display("FAIL %s prefill tready: got %b want 0", name, s_axis.tready);
    end
  endtask

  task automatic run_stream(input string name, input int n_frame_cyc, input int drop_at,
                            input int inject_at, input logic [31:0] fn_end);
    logic [1:0] e;
    logic [1:0] got;
    @(negedge bclk);
    i_enable = 1'b1;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge bclk);
      e   = exp_q.pop_front();
      got = {lrck, datao};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cyc %0d lrck/datao: got %b want %b", name, i, got, e);
      end
      if (i == n_frame_cyc - 1) begin
        checks++;
        if (o_frame_num !== fn_end - 32'd1) begin
          errors++;
          $display("FAIL %s frame_num in last cycle: got %0d want %0d", name, o_frame_num, fn_end - 32'd1);
        end
      end
      if (i == n_frame_cyc) begin
        checks++;
        if (o_frame_num !== fn_end) begin
          errors++;
          $display("FAIL %s frame_num after frame: got %0d want %0d", name, o_frame_num, fn_end);
        end
      end
      if (i == inject_at) while (pend_q.size() > 0) src_q.push_back(pend_q.pop_front());
      if (i == drop_at || i == n_frame_cyc - 1) i_enable = 1'b0;
    end
  endtask

  task automatic check_counts(input string name, input int unf, input int terr);
    checks++;
    if (o_underflow_count !== 16'(unf)) begin
      errors++;
      $display("FAIL %s underflow_count: got %0d want %0d", name, o_underflow_count, unf);
    end
    checks++;
    if (o_tlast_err_count !== 16'(terr)) begin
      errors++;
      $display("FAIL %s tlast_err_count: got %0d want %0d", name, o_tlast_err_count, terr);
    end
  endtask

  task automatic test_reset();
    set_cfg(2, 32, 24, 1'b1, 1'b1);
    rst_n    = 1'b0;
    i_enable = 1'b0;
    repeat (2) @(negedge bclk);
    #1;
    checks++;
    if ({lrck, datao, s_axis.tready, o_dbg_state} !== 4'b1000) begin
      errors++;
      $display("FAIL reset lrck/datao/tready/state: got %b want 1000", {lrck, datao, s_axis.tready, o_dbg_state});
    end
    checks++;
    if ({o_frame_num, o_underflow_count, o_tlast_err_count} !== 64'd0) begin
      errors++;
      $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", o_frame_num, o_underflow_count, o_tlast_err_count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis.tready !== 1'b1) begin
      errors++;
      $display("FAIL reset release tready: got %b want 1", s_axis.tready);
    end
  endtask

  task automatic test_stereo_i2s();
    logic [7:0] bytes[6] = '{8'hA5, 8'h5A, 8'h3C, 8'h12, 8'h34, 8'h56};
    do_reset();
    set_cfg(2, 32, 24, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      src_q.push_back({(i == 5), bytes[i]});
      slot_q.push_back(bytes[i]);
    end
    prefill_check("stereo");
    build_exp(1, 2, 32, 24, 1'b1, 1'b1, 2);
    run_stream("stereo", 64, -1, -1, 32'd1);
    check_counts("stereo", 0, 0);
  endtask

  task automatic test_tdm_back_to_back();
    logic [7:0] v;
    do_reset();
    set_cfg(4, 16, 16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 255));
      src_q.push_back({(i % 8 == 7), v});
      slot_q.push_back(v);
    end
    prefill_check("tdm");
    build_exp(2, 4, 16, 16, 1'b0, 1'b0, 2);
    run_stream("tdm", 128, -1, -1, 32'd2);
    check_counts("tdm", 0, 0);
  endtask

  task automatic test_underflow();
    do_reset();
    set_cfg(2, 16, 16, 1'b0, 1'b0);
    src_q.push_back({1'b0, 8'hC3});
    pend_q.push_back({1'b0, 8'h81});
    pend_q.push_back({1'b1, 8'h7E});
    slot_q.push_back(8'hC3);
    slot_q.push_back(8'h00);
    slot_q.push_back(8'h81);
    slot_q.push_back(8'h7E);
    prefill_check("underflow");
    build_exp(1, 2, 16, 16, 1'b0, 1'b0, 2);
    run_stream("underflow", 32, -1, 8, 32'd1);
    check_counts("underflow", 1, 0);
  endtask

  task automatic test_tlast_err();
    logic [7:0] bytes[6] = '{8'h11, 8'hE2, 8'h33, 8'h4C, 8'h95, 8'h66};
    do_reset();
    set_cfg(2, 24, 24, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      src_q.push_back({(i == 1), bytes[i]});
      slot_q.push_back(bytes[i]);
    end
    prefill_check("tlast");
    build_exp(1, 2, 24, 24, 1'b1, 1'b1, 2);
    run_stream("tlast", 48, -1, -1, 32'd1);
    check_counts("tlast", 0, 2);
  endtask

  task automatic test_enable_drop();
    do_reset();
    set_cfg(2, 16, 16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      src_q.push_back({(i == 3), 8'(8'h5A + i)});
      slot_q.push_back(8'(8'h5A + i));
    end
    prefill_check("drop");
    build_exp(1, 2, 16, 16, 1'b0, 1'b0, 5);
    run_stream("drop", 32, 5, -1, 32'd1);
    checks++;
    if ({o_frame_num, o_dbg_state} !== {32'd1, 1'b0}) begin
      errors++;
      $display("FAIL drop idle frame_num/state: got %0d/%b want 1/0", o_frame_num, o_dbg_state);
    end
    check_counts("drop", 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    set_cfg(2, 16, 16, 1'b1, 1'b0);
    @(negedge bclk);
    i_enable = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge bclk);
      if (i == 8) src_q.push_back({1'b0, 8'h99});
    end
    checks++;
    if ({lrck, o_dbg_state, o_underflow_count} !== {1'b0, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL midreset pre lrck/state/underflow: got %b/%b/%0d want 0/1/2", lrck, o_dbg_state, o_underflow_count);
    end
    rst_n    = 1'b0;
    i_enable = 1'b0;
    #2;
    checks++;
    if (s_axis.tready !== 1'b0) begin
      errors++;
      $display("FAIL midreset tready while reset low: got %b want 0", s_axis.tready);
    end
    @(negedge bclk);
    rst_n = 1'b1;
    #2;
    checks++;
    if ({lrck, datao, o_dbg_state, s_axis.tready} !== 4'b1001) begin
      errors++;
      $display("FAIL midreset lrck/datao/state/tready: got %b want 1001", {lrck, datao, o_dbg_state, s_axis.tready});
    end
    check_counts("midreset", 0, 0);
    repeat (20) @(negedge bclk);
    checks++;
    if ({o_frame_num, lrck, datao} !== {32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset idle frame_num/lrck/datao: got %0d/%b/%b want 0/1/0", o_frame_num, lrck, datao);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i_enable = 1'b0;
    set_cfg(2, 32, 24, 1'b1, 1'b1);
    test_reset();
    test_stereo_i2s();
    test_tdm_back_to_back();
    test_underflow();
    test_tlast_err();
    test_enable_drop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
